mac_acc_ctrl: RTL and testbench

MAC_ACC_CTRL -- requirements
Module: mac_acc_ctrl

---
 rtl/mac_acc_ctrl.sv | 86 ++++++++
 tb/tb_mac_acc_ctrl.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/mac_acc_ctrl.sv
// Accumulation controller for a multiply-accumulate datapath.
// It sums a programmed number of 33-bit products on a shared external 34-bit adder.
module mac_acc_ctrl #(
    parameter int LEN_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [LEN_W-1:0] len,
    input  logic             abort,
    input  logic             in_valid,
    input  logic [32:0]      prod,
    output logic             in_ready,
    output logic [32:0]      add_a,
    output logic [33:0]      add_b,
    input  logic [33:0]      add_s,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [33:0]      acc_out,
    output logic             ovf,
    output logic             busy
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] ACC  = 2'd1;
    localparam logic [1:0] OUT  = 2'd2;

    logic [1:0]       state;
    logic [33:0]      acc;
    logic [LEN_W-1:0] cnt;

    assign add_a     = prod;
    assign add_b     = acc;
    assign acc_out   = acc;
    assign in_ready  = (state == ACC);
    assign out_valid = (state == OUT);
    assign busy      = (state != IDLE);

    // abort wins over every other event; acc and ovf are left as they were
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            acc   <= '0;
            cnt   <= '0;
            ovf   <= 1'b0;
        end else if (abort) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        acc <= '0;
                        ovf <= 1'b0;
                        if (len != '0) begin
                            state <= ACC;
                            cnt   <= len;
                        end else begin
                            state <= OUT;
                        end
                    end
                end
                ACC: begin
                    if (in_valid) begin
                        acc <= add_s;
                        cnt <= cnt - LEN_W'(1);
                        // the adder has no carry out, so a wrap shows as a smaller sum
                        if (add_s < acc) begin
                            ovf <= 1'b1;
                        end
                        if (cnt == LEN_W'(1)) begin
                            state <= OUT;
                        end
                    end
                end
                OUT: begin
                    if (out_ready) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mac_acc_ctrl.sv
// Self-checking bench for mac_acc_ctrl: directed scenarios plus randomized jobs
// compared against a plain-arithmetic model of the accumulation.
module tb_mac_acc_ctrl;

    localparam int LEN_W = 8;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             start = 1'b0;
    logic [LEN_W-1:0] len = '0;
    logic             abort = 1'b0;
    logic             in_valid = 1'b0;
    logic [32:0]      prod = '0;
    logic             out_ready = 1'b0;
    logic             in_ready;
    logic [32:0]      add_a;
    logic [33:0]      add_b;
    logic [33:0]      add_s;
    logic             out_valid;
    logic [33:0]      acc_out;
    logic             ovf;
    logic             busy;

    int checks = 0;
    int errors = 0;

    logic [32:0] prodQ[$];
    logic [33:0] expAcc;
    logic        expOvf;

    mac_acc_ctrl #(.LEN_W(LEN_W)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .len(len), .abort(abort),
        .in_valid(in_valid), .prod(prod), .in_ready(in_ready),
        .add_a(add_a), .add_b(add_b), .add_s(add_s),
        .out_valid(out_valid), .out_ready(out_ready), .acc_out(acc_out),
        .ovf(ovf), .busy(busy)
    );

    // external shared adder: 34-bit sum with prod zero-extended, no carry out
    assign add_s = {1'b0, add_a} + add_b;

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [63:0] observed,
                               input logic [63:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic st, input logic [LEN_W-1:0] ln,
                                 input logic iv, input logic [32:0] pr,
                                 input logic ab, input logic ordy);
        start     = st;
        len       = ln;
        in_valid  = iv;
        prod      = pr;
        abort     = ab;
        out_ready = ordy;
    endtask

    function automatic logic [32:0] rand33();
        return {1'($urandom_range(1, 0)), $urandom};
    endfunction

    // reference: running sum mod 2^34, sticky flag if any single step exceeds 2^34-1
    function automatic void modelJob();
        longint unsigned s;
        expAcc = '0;
        expOvf = 1'b0;
        foreach (prodQ[i]) begin
            s = longint'(expAcc) + longint'(prodQ[i]);
            if (s >= 64'h4_0000_0000) expOvf = 1'b1;
            expAcc = s[33:0];
        end
    endfunction

    // one complete job from IDLE at a negedge, through the output handshake, back to IDLE
    task automatic runJob(input int n, input int gapLo, input int gapHi, input int bp);
        int gap;
        modelJob();
        applyStimulus(1'b1, LEN_W'(n), 1'b0, rand33(), 1'b0, 1'b0);
        @(negedge clk);
        applyStimulus(1'b0, LEN_W'($urandom), 1'b0, rand33(), 1'b0, 1'b0);
        checkOutput("job_busy", busy, 1);
        for (int i = 0; i < n; i++) begin
            gap = $urandom_range(gapHi, gapLo);
            repeat (gap) begin
                applyStimulus(1'b0, LEN_W'($urandom), 1'b0, rand33(), 1'b0, 1'b0);
                checkOutput("gap_in_ready", in_ready, 1);
                checkOutput("gap_out_valid", out_valid, 0);
                @(negedge clk);
            end
            applyStimulus(1'b1, LEN_W'($urandom), 1'b1, prodQ[i], 1'b0, 1'b0);
            checkOutput("acc_in_ready", in_ready, 1);
            checkOutput("early_out_valid", out_valid, 0);
            @(negedge clk);
        end
        applyStimulus(1'b1, LEN_W'($urandom), 1'b0, rand33(), 1'b0, 1'b0);
        for (int k = 0; k <= bp; k++) begin
            checkOutput("out_valid", out_valid, 1);
            checkOutput("out_in_ready", in_ready, 0);
            checkOutput("out_acc", acc_out, expAcc);
            checkOutput("out_ovf", ovf, expOvf);
            if (k < bp) @(negedge clk);
        end
        out_ready = 1'b1;
        @(negedge clk);
        applyStimulus(1'b0, '0, 1'b0, rand33(), 1'b0, 1'b0);
        checkOutput("post_hs_out_valid", out_valid, 0);
        checkOutput("post_hs_busy", busy, 0);
    endtask

    initial begin
        logic [32:0] p;

        // reset state
        #12;
        checkOutput("rst_busy", busy, 0);
        checkOutput("rst_out_valid", out_valid, 0);
        checkOutput("rst_in_ready", in_ready, 0);
        checkOutput("rst_acc", acc_out, 0);
        checkOutput("rst_ovf", ovf, 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // basic back-to-back accumulation
        prodQ = '{33'd5, 33'd7, 33'd9};
        runJob(3, 0, 0, 0);

        // gapped input with backpressure on the output
        prodQ = '{rand33(), rand33()};
        runJob(2, 3, 3, 4);

        // wrap-around boundary
        prodQ = '{33'h1_FFFF_FFFF, 33'h1_FFFF_FFFF};
        runJob(2, 0, 0, 0);
        prodQ.push_back(33'd2);
        runJob(3, 0, 1, 0);

        // zero-length job, which must also clear the sticky ovf from the job above
        prodQ.delete();
        runJob(0, 0, 0, 2);

        // abort together with the final accept
        applyStimulus(1'b1, LEN_W'(2), 1'b0, rand33(), 1'b0, 1'b0);
        @(negedge clk);
        applyStimulus(1'b0, '0, 1'b1, 33'd6, 1'b0, 1'b0);
        @(negedge clk);
        applyStimulus(1'b1, LEN_W'(1), 1'b1, 33'd10, 1'b1, 1'b1);
        @(negedge clk);
        applyStimulus(1'b0, '0, 1'b0, rand33(), 1'b0, 1'b0);
        checkOutput("abort_busy", busy, 0);
        checkOutput("abort_out_valid", out_valid, 0);
        checkOutput("abort_acc_hold", acc_out, 6);
        checkOutput("abort_ovf_hold", ovf, 0);
        repeat (3) begin
            @(negedge clk);
            checkOutput("abort_no_out", out_valid, 0);
        end
        prodQ = '{33'd4};
        runJob(1, 0, 0, 0);

        // abort while holding a result, and abort beating start in IDLE
        p = rand33();
        applyStimulus(1'b1, LEN_W'(1), 1'b0, rand33(), 1'b0, 1'b0);
        @(negedge clk);
        applyStimulus(1'b0, '0, 1'b1, p, 1'b0, 1'b0);
        @(negedge clk);
        checkOutput("pre_abort_out_valid", out_valid, 1);
        applyStimulus(1'b0, '0, 1'b0, rand33(), 1'b1, 1'b1);
        @(negedge clk);
        checkOutput("abort_out_busy", busy, 0);
        checkOutput("abort_out_acc", acc_out, {1'b0, p});
        applyStimulus(1'b1, LEN_W'(5), 1'b0, rand33(), 1'b1, 1'b0);
        @(negedge clk);
        applyStimulus(1'b0, '0, 1'b0, rand33(), 1'b0, 1'b0);
        checkOutput("abort_start_busy", busy, 0);

        // asynchronous reset in the middle of a job
        p = rand33();
        applyStimulus(1'b1, LEN_W'(3), 1'b0, rand33(), 1'b0, 1'b0);
        @(negedge clk);
        applyStimulus(1'b0, '0, 1'b1, p, 1'b0, 1'b0);
        @(negedge clk);
        applyStimulus(1'b0, '0, 1'b1, rand33(), 1'b0, 1'b0);
        checkOutput("pre_rst_acc", acc_out, {1'b0, p});
        #2;
        rst_n = 1'b0;
        applyStimulus(1'b1, LEN_W'(3), 1'b1, rand33(), 1'b0, 1'b0);
        #1;
        checkOutput("arst_busy", busy, 0);
        checkOutput("arst_in_ready", in_ready, 0);
        checkOutput("arst_out_valid", out_valid, 0);
        checkOutput("arst_acc", acc_out, 0);
        checkOutput("arst_ovf", ovf, 0);
        @(negedge clk);
        checkOutput("arst_start_ignored", busy, 0);
        rst_n = 1'b1;
        applyStimulus(1'b0, '0, 1'b0, rand33(), 1'b0, 1'b0);
        @(negedge clk);
        checkOutput("post_rst_idle", busy, 0);

        // maximum length job with repeated wraps
        prodQ.delete();
        for (int i = 0; i < 255; i++) prodQ.push_back(33'h1_FFFF_FFFF);
        runJob(255, 0, 0, 0);

        // randomized jobs
        for (int j = 0; j < 25; j++) begin
            int n;
            n = $urandom_range(6, 0);
            prodQ.delete();
            for (int i = 0; i < n; i++) begin
                if ($urandom_range(1, 0) == 1) prodQ.push_back(33'h1_FFFF_FFFF - 33'($urandom_range(15, 0)));
                else prodQ.push_back(rand33());
            end
            runJob(n, 0, 2, $urandom_range(3, 0));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
